// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types for the immediate-generation stage
//
// Purpose: immediate format select codes, stage occupancy states and a
// helper that identifies PC-relative control-flow formats.
// The stage entry record (imm_entry_t) depends on DATA_WIDTH, so it is
// declared inside imm_gen_stage where that parameter is in scope.
package riscv_pkg;

    localparam int INSTR_WIDTH = 32;

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_B     = 3'b010,
        IMM_U     = 3'b011,
        IMM_J     = 3'b100,
        IMM_CSR   = 3'b101,
        IMM_SHAMT = 3'b110,
        IMM_RSV   = 3'b111
    } imm_src_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

    // Only branch and jump targets are alignment-checked.
    function automatic logic is_pc_rel(input imm_src_t src);
        return (src == IMM_B) || (src == IMM_J);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational immediate extender
//
// Purpose: builds the DATA_WIDTH immediate for the selected format.
// Ports:
//   instr_i    in  32          raw instruction word
//   imm_src_i  in  imm_src_t   format select
//   imm_o      out DATA_WIDTH  extended immediate
//   illegal_o  out 1           reserved format code selected
module imm_decode
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  imm_src_t               imm_src_i,
    output logic [DATA_WIDTH-1:0]  imm_o,
    output logic                   illegal_o
);

    logic sign;
    assign sign = instr_i[31];

    // The opcode field never contributes to any immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr_i[6:0];

    always_comb begin
        imm_o     = '0;
        illegal_o = 1'b0;
        unique case (imm_src_i)
            IMM_I: imm_o = {{(DATA_WIDTH-12){sign}}, instr_i[31:20]};
            IMM_S: imm_o = {{(DATA_WIDTH-12){sign}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm_o = {{(DATA_WIDTH-13){sign}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm_o = {{(DATA_WIDTH-32){sign}}, instr_i[31:12], 12'h000};
            IMM_J: imm_o = {{(DATA_WIDTH-21){sign}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            IMM_CSR: imm_o = {{(DATA_WIDTH-5){1'b0}}, instr_i[19:15]};
            IMM_SHAMT: begin
                // RV64 shifts use a 6-bit shamt; RV32 only 5 bits.
                if (DATA_WIDTH == 64)
                    imm_o = {{(DATA_WIDTH-6){1'b0}}, instr_i[25:20]};
                else
                    imm_o = {{(DATA_WIDTH-5){1'b0}}, instr_i[24:20]};
            end
            IMM_RSV: begin
                imm_o     = '0;
                illegal_o = 1'b1;
            end
            default: begin
                imm_o     = '0;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered, handshaked immediate-generation stage
//
// Purpose: extends the immediate, forms pc+imm and the misalign/illegal
// flags on input, and holds results in a main+skid two-entry buffer.
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i
//   in_valid_i/in_ready_o, instr_i, pc_i, ImmSrc_i      upstream side
//   out_valid_o/out_ready_i, ImmExt_o, Target_o,
//   Instr_o, Pc_o, Misalign_o, Illegal_o                downstream side
module imm_gen_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit SUPPORT_C  = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic [DATA_WIDTH-1:0]  pc_i,
    input  logic [2:0]             ImmSrc_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_WIDTH-1:0]  ImmExt_o,
    output logic [DATA_WIDTH-1:0]  Target_o,
    output logic [INSTR_WIDTH-1:0] Instr_o,
    output logic [DATA_WIDTH-1:0]  Pc_o,
    output logic                   Misalign_o,
    output logic                   Illegal_o
);

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [DATA_WIDTH-1:0]  pc;
        logic [DATA_WIDTH-1:0]  imm;
        logic [DATA_WIDTH-1:0]  target;
        logic                   misalign;
        logic                   illegal;
    } imm_entry_t;

    imm_src_t              src;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] target;
    logic                  illegal;
    logic                  misalign;
    imm_entry_t            new_entry;

    occ_state_t state_q, state_d;
    imm_entry_t main_q, main_d;
    imm_entry_t skid_q, skid_d;

    logic accept;
    logic pop;

    assign src = imm_src_t'(ImmSrc_i);

    imm_decode #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_imm_decode (
        .instr_i  (instr_i),
        .imm_src_i(src),
        .imm_o    (imm),
        .illegal_o(illegal)
    );

    // Wraps modulo 2^DATA_WIDTH; carry out is intentionally dropped.
    assign target = pc_i + imm;

    always_comb begin
        misalign = 1'b0;
        if (is_pc_rel(src)) begin
            if (SUPPORT_C)
                misalign = target[0];
            else
                misalign = |target[1:0];
        end
    end

    always_comb begin
        new_entry.instr    = instr_i;
        new_entry.pc       = pc_i;
        new_entry.imm      = imm;
        new_entry.target   = target;
        new_entry.misalign = misalign;
        new_entry.illegal  = illegal;
    end

    // Ready depends only on registered state so downstream backpressure
    // never reaches upstream combinationally.
    assign in_ready_o  = (state_q != OCC_FULL);
    assign out_valid_o = (state_q != OCC_EMPTY);

    assign accept = in_valid_i && in_ready_o && !flush_i;
    assign pop    = out_valid_o && out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            // Data registers keep stale contents; only occupancy is cleared.
            state_d = OCC_EMPTY;
        end else begin
            unique case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        main_d  = new_entry;
                        state_d = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && pop) begin
                        main_d = new_entry;
                    end else if (accept) begin
                        skid_d  = new_entry;
                        state_d = OCC_FULL;
                    end else if (pop) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = OCC_ONE;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= OCC_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign ImmExt_o   = main_q.imm;
    assign Target_o   = main_q.target;
    assign Instr_o    = main_q.instr;
    assign Pc_o       = main_q.pc;
    assign Misalign_o = main_q.misalign;
    assign Illegal_o  = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - self-checking bench for imm_gen_stage
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [2:0]  src;

    logic        a_in_ready, a_out_valid, a_mis, a_ill;
    logic [31:0] a_imm, a_tgt, a_instr, a_pc;
    logic        c_in_ready, c_out_valid, c_mis, c_ill;
    logic [31:0] c_imm, c_tgt, c_instr, c_pc;
    logic        w_in_ready, w_out_valid, w_mis, w_ill;
    logic [63:0] w_imm, w_tgt, w_pc;
    logic [31:0] w_instr;

    int checks   = 0;
    int failures = 0;
    int cnt      = 0;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [31:0] imm32;
        logic [31:0] tgt32;
        logic        mis32;
        logic        mis32c;
        logic [63:0] imm64;
        logic [63:0] tgt64;
        logic        mis64;
        logic        ill;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    imm_gen_stage #(.DATA_WIDTH(32), .SUPPORT_C(1'b0)) dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(a_in_ready),
        .instr_i(instr), .pc_i(pc[31:0]), .ImmSrc_i(src),
        .out_valid_o(a_out_valid), .out_ready_i(out_ready),
        .ImmExt_o(a_imm), .Target_o(a_tgt), .Instr_o(a_instr), .Pc_o(a_pc),
        .Misalign_o(a_mis), .Illegal_o(a_ill)
    );

    imm_gen_stage #(.DATA_WIDTH(32), .SUPPORT_C(1'b1)) dut_c (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(c_in_ready),
        .instr_i(instr), .pc_i(pc[31:0]), .ImmSrc_i(src),
        .out_valid_o(c_out_valid), .out_ready_i(out_ready),
        .ImmExt_o(c_imm), .Target_o(c_tgt), .Instr_o(c_instr), .Pc_o(c_pc),
        .Misalign_o(c_mis), .Illegal_o(c_ill)
    );

    imm_gen_stage #(.DATA_WIDTH(64), .SUPPORT_C(1'b0)) dut_w (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(w_in_ready),
        .instr_i(instr), .pc_i(pc), .ImmSrc_i(src),
        .out_valid_o(w_out_valid), .out_ready_i(out_ready),
        .ImmExt_o(w_imm), .Target_o(w_tgt), .Instr_o(w_instr), .Pc_o(w_pc),
        .Misalign_o(w_mis), .Illegal_o(w_ill)
    );

    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] s,
                                            input bit w64);
        logic signed [63:0] v;
        case (s)
            3'd0: v = $signed(ins[31:20]);
            3'd1: v = $signed({ins[31:25], ins[11:7]});
            3'd2: v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
            3'd3: v = $signed({ins[31:12], 12'h000});
            3'd4: v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
            3'd5: v = {59'd0, ins[19:15]};
            3'd6: v = w64 ? {58'd0, ins[25:20]} : {59'd0, ins[24:20]};
            default: v = 64'd0;
        endcase
        return v;
    endfunction

    function automatic exp_t ref_entry(input logic [31:0] ins, input logic [63:0] p,
                                       input logic [2:0] s);
        exp_t e;
        logic bj;
        logic [63:0] i32;
        bj       = (s == 3'd2) || (s == 3'd4);
        i32      = ref_imm(ins, s, 1'b0);
        e.instr  = ins;
        e.pc     = p;
        e.imm32  = i32[31:0];
        e.tgt32  = p[31:0] + i32[31:0];
        e.mis32  = bj && (e.tgt32[1:0] != 2'b00);
        e.mis32c = bj && e.tgt32[0];
        e.imm64  = ref_imm(ins, s, 1'b1);
        e.tgt64  = p + e.imm64;
        e.mis64  = bj && (e.tgt64[1:0] != 2'b00);
        e.ill    = (s == 3'd7);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a_imm"}, 64'(a_imm), 64'd0);
        chk({tag, "_a_tgt"}, 64'(a_tgt), 64'd0);
        chk({tag, "_a_instr"}, 64'(a_instr), 64'd0);
        chk({tag, "_a_pc"}, 64'(a_pc), 64'd0);
        chk({tag, "_a_flags"}, 64'({a_mis, a_ill}), 64'd0);
        chk({tag, "_c_imm"}, 64'(c_imm), 64'd0);
        chk({tag, "_w_imm"}, w_imm, 64'd0);
        chk({tag, "_w_tgt"}, w_tgt, 64'd0);
        chk({tag, "_w_pc"}, w_pc, 64'd0);
        chk({tag, "_w_flags"}, 64'({w_mis, w_ill}), 64'd0);
    endtask

    // Called mid-cycle (after negedge) with inputs already driven:
    // check outputs against the model, advance the model, step one clock.
    task automatic cycle();
        logic acc, pop;
        exp_t e;
        chk("a_out_valid", 64'(a_out_valid), 64'(cnt > 0));
        chk("a_in_ready", 64'(a_in_ready), 64'(cnt < 2));
        chk("c_out_valid", 64'(c_out_valid), 64'(cnt > 0));
        chk("w_out_valid", 64'(w_out_valid), 64'(cnt > 0));
        chk("w_in_ready", 64'(w_in_ready), 64'(cnt < 2));
        if (cnt > 0) begin
            e = q[0];
            chk("a_imm", 64'(a_imm), 64'(e.imm32));
            chk("a_tgt", 64'(a_tgt), 64'(e.tgt32));
            chk("a_instr", 64'(a_instr), 64'(e.instr));
            chk("a_pc", 64'(a_pc), 64'(e.pc[31:0]));
            chk("a_mis", 64'(a_mis), 64'(e.mis32));
            chk("a_ill", 64'(a_ill), 64'(e.ill));
            chk("c_mis", 64'(c_mis), 64'(e.mis32c));
            chk("c_tgt", 64'(c_tgt), 64'(e.tgt32));
            chk("w_imm", w_imm, e.imm64);
            chk("w_tgt", w_tgt, e.tgt64);
            chk("w_instr", 64'(w_instr), 64'(e.instr));
            chk("w_pc", w_pc, e.pc);
            chk("w_mis", 64'(w_mis), 64'(e.mis64));
            chk("w_ill", 64'(w_ill), 64'(e.ill));
        end
        acc = in_valid && (cnt < 2) && !flush;
        pop = (cnt > 0) && out_ready;
        if (rst || flush) begin
            q.delete();
            cnt = 0;
        end else begin
            if (pop) begin
                void'(q.pop_front());
                cnt--;
            end
            if (acc) begin
                q.push_back(ref_entry(instr, pc, src));
                cnt++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] p,
                         input logic [2:0] s);
        in_valid = v;
        instr    = ins;
        pc       = p;
        src      = s;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = '0; pc = '0; src = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);
        chk_zero("rst");

        // I-type addi x1,x0,-1
        drive(1'b1, 32'hFFF00093, 64'h100, 3'd0); cycle();
        chk("i_imm_const", 64'(a_imm), 64'hFFFF_FFFF);
        chk("i_tgt_const", 64'(a_tgt), 64'hFF);
        // B-type beq imm=-4
        drive(1'b1, 32'hFE000EE3, 64'h200, 3'd2); cycle();
        chk("b_imm_const", 64'(a_imm), 64'hFFFF_FFFC);
        chk("b_tgt_const", 64'(a_tgt), 64'h1FC);
        chk("b_mis_const", 64'(a_mis), 64'd0);
        // J-type imm=+2
        drive(1'b1, 32'h0020006F, 64'h100, 3'd4); cycle();
        chk("j_mis_noc", 64'(a_mis), 64'd1);
        chk("j_mis_c", 64'(c_mis), 64'd0);
        // Reserved code
        drive(1'b1, 32'hDEADBEEF, 64'h300, 3'd7); cycle();
        chk("rsv_imm", 64'(a_imm), 64'd0);
        chk("rsv_ill", 64'(a_ill), 64'd1);
        // U-type on RV64
        drive(1'b1, 32'h800000B7, 64'h0, 3'd3); cycle();
        chk("u64_imm", w_imm, 64'hFFFF_FFFF_8000_0000);
        // Remaining formats including RV64 shamt bit 25
        drive(1'b1, 32'hFE1FF0A3, 64'h400, 3'd1); cycle();
        drive(1'b1, 32'h0BF7D073, 64'h404, 3'd5); cycle();
        drive(1'b1, 32'h03F0D093, 64'h408, 3'd6); cycle();
        drive(1'b0, 32'h0, 64'h0, 3'd0); cycle();

        // Backpressure: A, B queued, ready drops, then drain in order
        out_ready = 1'b0;
        drive(1'b1, 32'h00A00093, 64'h1000, 3'd0); cycle();
        drive(1'b1, 32'h00B00093, 64'h1004, 3'd0); cycle();
        drive(1'b1, 32'h00C00093, 64'h1008, 3'd0); cycle();
        chk("full_in_ready", 64'(a_in_ready), 64'd0);
        drive(1'b0, 32'h0, 64'h0, 3'd0); cycle();
        out_ready = 1'b1;
        repeat (3) cycle();

        // Flush while FULL with a concurrent input
        out_ready = 1'b0;
        drive(1'b1, 32'h11100093, 64'h2000, 3'd0); cycle();
        drive(1'b1, 32'h22200093, 64'h2004, 3'd0); cycle();
        flush = 1'b1;
        drive(1'b1, 32'h33300093, 64'h2008, 3'd0); cycle();
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 64'h0, 3'd0);
        chk("flush_out_valid", 64'(a_out_valid), 64'd0);
        chk("flush_in_ready", 64'(a_in_ready), 64'd1);
        cycle();

        // Randomised traffic with occasional flush
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom}, 3'($urandom_range(0, 7)));
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            cycle();
        end
        flush = 1'b0;

        // Reset while FULL
        out_ready = 1'b0;
        drive(1'b1, 32'h44400093, 64'h3000, 3'd0); cycle();
        drive(1'b1, 32'h55500093, 64'h3004, 3'd0); cycle();
        drive(1'b1, 32'h66600093, 64'h3008, 3'd0); cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive(1'b0, 32'h0, 64'h0, 3'd0);
        out_ready = 1'b1;
        chk_zero("rst_full");
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
